// File: rtl/spi_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_receiver : mode-0 SPI target, 8-bit MSB-first frames into a FWFT FIFO   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module spi_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int SPI_FREQ   = 5000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         CLK_100MHz,
  input  logic                         RST_N,
  input  logic                         SCK,
  input  logic                         SDI,
  input  logic                         CSX,
  output logic [7:0]                   OUT,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic                         ACTIVE,
  output logic [$clog2(FIFO_DEPTH):0]  COUNT,
  output logic                         FRAME_ERR,
  output logic                         OVERRUN
);

  localparam int                    c_addr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_addr_w:0]     c_depth  = FIFO_DEPTH[c_addr_w:0];

  generate
    if ((CLK_FREQ / SPI_FREQ) < 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("spi_receiver: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RECEIVE   = 2'd2
  } state_t;

  state_t r_state, w_state_n;

  logic [2:0] r_sck_sync;
  logic [2:0] r_csx_sync;
  logic [1:0] r_sdi_sync;
  logic [1:0] r_settle;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;

  logic w_sck_rise, w_csx_fall, w_csx_rise, w_csx_s, w_sdi_s;
  logic w_push, w_start, w_shift_en, w_frame_err;
  logic [7:0] w_byte;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_addr_w:0]   r_count;
  logic                w_pop, w_full, w_wr;

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_csx_fall = ~r_csx_sync[1] & r_csx_sync[2];
  assign w_csx_rise = r_csx_sync[1] & ~r_csx_sync[2];
  assign w_csx_s    = r_csx_sync[1];
  assign w_sdi_s    = r_sdi_sync[1];
  assign w_byte     = {r_shift, w_sdi_s};

  // The synchroniser reset values are placeholders, so WAIT_IDLE only trusts
  // CSX once real pin samples have flushed the whole chain.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      r_sck_sync <= 3'b000;
      r_csx_sync <= 3'b111;
      r_sdi_sync <= 2'b00;
      r_settle   <= 2'd0;
      r_state    <= ST_WAIT_IDLE;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], SCK};
      r_csx_sync <= {r_csx_sync[1:0], CSX};
      r_sdi_sync <= {r_sdi_sync[0], SDI};
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      r_state    <= w_state_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_push      = 1'b0;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        if (r_settle == 2'd3 && w_csx_s) w_state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_csx_fall) begin
          w_state_n = ST_RECEIVE;
          w_start   = 1'b1;
        end
      end
      ST_RECEIVE: begin
        if (w_sck_rise) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_push = 1'b1;
        end
        // A byte completing on the same cycle CSX rises still counts as clean.
        if (w_csx_rise) begin
          w_state_n = ST_IDLE;
          if (r_bit_cnt != 3'd0 && !w_push) w_frame_err = 1'b1;
        end
      end
      default: w_state_n = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      r_shift   <= 7'd0;
      r_bit_cnt <= 3'd0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= w_frame_err;
      if (w_start) begin
        r_shift   <= 7'd0;
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_shift   <= w_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign w_pop  = OUT_READY & (r_count != '0);
  assign w_full = (r_count == c_depth);
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge CLK_100MHz) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_byte;
  end

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      OVERRUN  <= 1'b0;
    end else begin
      OVERRUN <= w_push & w_full & ~w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign OUT_VALID = (r_count != '0);
  assign OUT       = OUT_VALID ? r_mem[r_rd_ptr] : 8'h00;
  assign COUNT     = r_count;
  assign ACTIVE    = (r_state == ST_RECEIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_receiver : directed bench for spi_receiver at 5 MHz SCK              |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_spi_receiver;

  logic       CLK_100MHz = 1'b0;
  logic       RST_N, SCK, SDI, CSX, OUT_READY;
  logic [7:0] OUT;
  logic       OUT_VALID, ACTIVE, FRAME_ERR, OVERRUN;
  logic [2:0] COUNT;

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;

  spi_receiver #(
    .CLK_FREQ  (100000000),
    .SPI_FREQ  (5000000),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK_100MHz(CLK_100MHz),
    .RST_N     (RST_N),
    .SCK       (SCK),
    .SDI       (SDI),
    .CSX       (CSX),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ACTIVE    (ACTIVE),
    .COUNT     (COUNT),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  always @(negedge CLK_100MHz) begin
    if (FRAME_ERR === 1'b1) fe_cnt++;
    if (OVERRUN === 1'b1)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SCK high for 100 ns; optionally pulse OUT_READY across the edge where the
  // 8th bit lands (third clock edge after SCK rises).
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit pop_last);
    for (int i = 7; i > 7 - nbits; i--) begin
      SDI = b[i];
      #100 SCK = 1'b1;
      if (pop_last && i == 0) begin
        #20 OUT_READY = 1'b1;
        #10 OUT_READY = 1'b0;
        #70;
      end else begin
        #100;
      end
      SCK = 1'b0;
    end
  endtask

  task automatic cs_low();
    CSX = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100 CSX = 1'b1;
    #200;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
    check({tag, "_data"}, {24'd0, OUT}, {24'd0, exp});
    OUT_READY = 1'b1;
    #10 OUT_READY = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; SCK = 1'b0; SDI = 1'b0; CSX = 1'b1; OUT_READY = 1'b0;
    #30;
    check("rst_out",   {24'd0, OUT}, 32'h0);
    check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_count", {29'd0, COUNT}, 32'd0);
    check("rst_active", {31'd0, ACTIVE}, 32'd0);
    check("rst_ferr",  {31'd0, FRAME_ERR}, 32'd0);
    check("rst_ovr",   {31'd0, OVERRUN}, 32'd0);
    #20 RST_N = 1'b1;
    #200;

    // 1: single byte, consumer stalled
    cs_low();
    check("t1_active", {31'd0, ACTIVE}, 32'd1);
    send_bits(8'hA5, 8, 1'b0);
    cs_high();
    check("t1_active_end", {31'd0, ACTIVE}, 32'd0);
    check("t1_count", {29'd0, COUNT}, 32'd1);
    check("t1_ferr_cnt", fe_cnt, 32'd0);
    check("t1_ovr_cnt", ov_cnt, 32'd0);
    pop_check("t1_pop", 8'hA5);
    #10;
    check("t1_count_empty", {29'd0, COUNT}, 32'd0);
    check("t1_valid_empty", {31'd0, OUT_VALID}, 32'd0);
    OUT_READY = 1'b1;  // pop while empty is ignored
    #20 OUT_READY = 1'b0;
    check("t1_empty_pop", {29'd0, COUNT}, 32'd0);

    // 2: four bytes in one frame, drained in order
    cs_low();
    send_bits(8'h01, 8, 1'b0);
    send_bits(8'h80, 8, 1'b0);
    send_bits(8'hFF, 8, 1'b0);
    send_bits(8'h3C, 8, 1'b0);
    cs_high();
    check("t2_count4", {29'd0, COUNT}, 32'd4);
    pop_check("t2_b0", 8'h01);
    pop_check("t2_b1", 8'h80);
    #10 check("t2_count2", {29'd0, COUNT}, 32'd2);
    pop_check("t2_b2", 8'hFF);
    pop_check("t2_b3", 8'h3C);
    #10 check("t2_count0", {29'd0, COUNT}, 32'd0);

    // 3: six bytes into a depth-4 FIFO
    cs_low();
    send_bits(8'h11, 8, 1'b0);
    send_bits(8'h22, 8, 1'b0);
    send_bits(8'h33, 8, 1'b0);
    send_bits(8'h44, 8, 1'b0);
    send_bits(8'h55, 8, 1'b0);
    send_bits(8'h66, 8, 1'b0);
    cs_high();
    check("t3_count", {29'd0, COUNT}, 32'd4);
    check("t3_ovr_cnt", ov_cnt, 32'd2);
    check("t3_head", {24'd0, OUT}, 32'h11);

    // 6: full FIFO, pop coincides with the push of a new byte
    cs_low();
    send_bits(8'h99, 8, 1'b1);
    cs_high();
    check("t6_count", {29'd0, COUNT}, 32'd4);
    check("t6_ovr_cnt", ov_cnt, 32'd2);
    pop_check("t6_b0", 8'h22);
    pop_check("t6_b1", 8'h33);
    pop_check("t6_b2", 8'h44);
    pop_check("t6_b3", 8'h99);
    #10 check("t6_count0", {29'd0, COUNT}, 32'd0);

    // 4: partial byte then a clean frame
    cs_low();
    send_bits(8'h1F, 5, 1'b0);
    cs_high();
    check("t4_ferr_cnt", fe_cnt, 32'd1);
    check("t4_count", {29'd0, COUNT}, 32'd0);
    check("t4_active", {31'd0, ACTIVE}, 32'd0);
    cs_low();
    send_bits(8'h5A, 8, 1'b0);
    cs_high();
    check("t4_count1", {29'd0, COUNT}, 32'd1);
    check("t4_ferr_cnt2", fe_cnt, 32'd1);
    pop_check("t4_pop", 8'h5A);

    // 5: CSX held low across reset release; that frame must be ignored
    CSX = 1'b0;
    #100 RST_N = 1'b0;
    #50 RST_N = 1'b1;
    send_bits(8'h77, 2, 1'b0);
    check("t5_no_join", {31'd0, ACTIVE}, 32'd0);
    send_bits(8'h77 << 2, 6, 1'b0);
    cs_high();
    check("t5_count0", {29'd0, COUNT}, 32'd0);
    cs_low();
    send_bits(8'h42, 8, 1'b0);
    cs_high();
    check("t5_count1", {29'd0, COUNT}, 32'd1);
    check("t5_ferr_cnt", fe_cnt, 32'd1);
    pop_check("t5_pop", 8'h42);
    #10 check("t5_count_end", {29'd0, COUNT}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
